// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: AES-128 key-schedule sequencer sharing one external key S-box
module key_expand_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [127:0] i_key_in,
    output logic [7:0]   o_sbox_in,
    input  logic [7:0]   i_sbox_out,
    output logic [127:0] o_round_key,
    output logic [3:0]   o_rk_round,
    output logic         o_rk_valid,
    input  logic         i_rk_ready,
    output logic         o_busy,
    output logic         o_done
);
    typedef enum logic [1:0] {IDLE, OUT, SUB, EXP} state_t;

    // Rcon for round r lives at index r-1, so the current round number selects it directly
    localparam logic [7:0] RCON [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                         8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    state_t       r_state, w_next;
    logic [31:0]  r_w0, r_w1, r_w2, r_w3, r_temp;
    logic [1:0]   r_cnt;
    logic [127:0] r_round_key;
    logic [3:0]   r_rk_round;
    logic         r_rk_valid, r_busy, r_done;
    logic         w_xfer, w_last;
    logic [7:0]   w_rot_byte;
    logic [31:0]  w_t, w_n0, w_n1, w_n2, w_n3;

    assign w_xfer      = r_state == OUT && r_rk_valid && i_rk_ready;
    assign w_last      = r_rk_round == 4'd10;
    assign w_rot_byte  = r_cnt == 2'd0 ? r_w3[23:16] :
                         r_cnt == 2'd1 ? r_w3[15:8]  :
                         r_cnt == 2'd2 ? r_w3[7:0]   : r_w3[31:24];
    assign o_sbox_in   = r_state == SUB ? w_rot_byte : 8'h00;
    assign w_t         = r_temp ^ {RCON[r_rk_round], 24'h0};
    assign w_n0        = r_w0 ^ w_t;
    assign w_n1        = r_w1 ^ w_n0;
    assign w_n2        = r_w2 ^ w_n1;
    assign w_n3        = r_w3 ^ w_n2;
    assign o_round_key = r_round_key;
    assign o_rk_round  = r_rk_round;
    assign o_rk_valid  = r_rk_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state: OUT waits for the consumer, SUB runs four S-box cycles, EXP is one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? OUT : IDLE;
            OUT:     w_next = w_xfer ? (w_last ? IDLE : SUB) : OUT;
            SUB:     w_next = r_cnt == 2'd3 ? EXP : SUB;
            default: w_next = OUT;
        endcase
    end

    // Datapath: key words, SubWord accumulator and the round-key handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {r_w0, r_w1, r_w2, r_w3} <= '0;
            r_temp      <= '0;
            r_cnt       <= '0;
            r_round_key <= '0;
            r_rk_round  <= '0;
            r_rk_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start) begin
                    {r_w0, r_w1, r_w2, r_w3} <= i_key_in;
                    r_round_key <= i_key_in;
                    r_rk_round  <= 4'd0;
                    r_rk_valid  <= 1'b1;
                    r_busy      <= 1'b1;
                end
                OUT: if (w_xfer) begin
                    r_rk_valid <= 1'b0;
                    r_cnt      <= 2'd0;
                    r_busy     <= !w_last;
                    r_done     <= w_last;
                end
                SUB: begin
                    r_temp[{~r_cnt, 3'b000} +: 8] <= i_sbox_out;
                    r_cnt <= r_cnt + 2'd1;
                end
                default: begin
                    {r_w0, r_w1, r_w2, r_w3} <= {w_n0, w_n1, w_n2, w_n3};
                    r_round_key <= {w_n0, w_n1, w_n2, w_n3};
                    r_rk_round  <= r_rk_round + 4'd1;
                    r_rk_valid  <= 1'b1;
                end
            endcase
        end
    end
endmodule
